mem_arbiter: RTL

- Two-requester arbiter and sequencer for the shared data port of the memory subsystem (ROM at 0x0000_0000, RAM at 0x1000_0000, GPIO iodev at 0x2000_0000).
- Requester 0 is the CPU load/store unit. Requester 1 is the debug/firmware loader.
- The block arbitrates round-robin, registers the winning request, and drives the memory port for exactly one cycle. It captures the asynchronous read data and returns a one-cycle response.
- It rejects illegal accesses without touching memory.

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for the shared memory data port.
// One access per grant: IDLE/RESP arbitrate -> ACCESS drives memory -> RESP returns the response.
module mem_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_m0_req,
  input  logic [2:0]  i_m0_we,
  input  logic [31:0] i_m0_addr,
  input  logic [31:0] i_m0_wdata,
  input  logic        i_m1_req,
  input  logic [2:0]  i_m1_we,
  input  logic [31:0] i_m1_addr,
  input  logic [31:0] i_m1_wdata,
  output logic        o_m0_gnt,
  output logic        o_m0_rvalid,
  output logic        o_m0_err,
  output logic [31:0] o_m0_rdata,
  output logic        o_m1_gnt,
  output logic        o_m1_rvalid,
  output logic        o_m1_err,
  output logic [31:0] o_m1_rdata,
  output logic [2:0]  o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_id;
  logic        r_err;
  logic        r_wr;
  logic [1:0]  r_gnt;
  logic [1:0]  r_rvalid;
  logic [31:0] r_rdata;
  logic [2:0]  r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic        w_any;
  logic        w_win;
  logic [2:0]  w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_err;

  always_comb begin
    w_any = i_m0_req | i_m1_req;
    if (i_m0_req && i_m1_req) w_win = FIXED_PRIO ? 1'b0 : ~r_last;
    else                      w_win = ~i_m0_req;
    w_we    = w_win ? i_m1_we    : i_m0_we;
    w_addr  = w_win ? i_m1_addr  : i_m0_addr;
    w_wdata = w_win ? i_m1_wdata : i_m0_wdata;
    // A read carries no size, so alignment is only checkable on writes.
    w_err = (w_addr[31:28] > 4'd2)
          | ((w_we & (w_we - 3'd1)) != 3'd0)
          | ((w_we == 3'b001) && (w_addr[1:0] != 2'd0))
          | ((w_we == 3'b010) && w_addr[0])
          | ((w_we != 3'd0) && (w_addr[31:28] == 4'd0));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_err       <= 1'b0;
      r_wr        <= 1'b0;
      r_gnt       <= 2'b00;
      r_rvalid    <= 2'b00;
      r_rdata     <= '0;
      r_mem_we    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_gnt    <= 2'b00;
      r_rvalid <= 2'b00;
      case (r_state)
        IDLE, RESP: begin
          if (w_any) begin
            r_state       <= ACCESS;
            r_id          <= w_win;
            r_last        <= w_win;
            r_gnt[w_win]  <= 1'b1;
            r_err         <= w_err;
            r_wr          <= (w_we != 3'd0);
            r_mem_we      <= w_err ? 3'd0 : w_we;
            r_mem_addr    <= w_addr;
            r_mem_wdata   <= w_wdata;
          end else begin
            r_state <= IDLE;
          end
        end
        ACCESS: begin
          r_state        <= RESP;
          r_mem_we       <= 3'd0;
          r_rdata        <= (r_err || r_wr) ? 32'd0 : i_mem_rdata;
          r_rvalid[r_id] <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_m0_gnt    = r_gnt[0];
  assign o_m1_gnt    = r_gnt[1];
  assign o_m0_rvalid = r_rvalid[0];
  assign o_m1_rvalid = r_rvalid[1];
  assign o_m0_err    = r_rvalid[0] & r_err;
  assign o_m1_err    = r_rvalid[1] & r_err;
  assign o_m0_rdata  = r_rvalid[0] ? r_rdata : 32'd0;
  assign o_m1_rdata  = r_rvalid[1] ? r_rdata : 32'd0;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;

endmodule
